// File: rtl/alu_muldiv_seq.sv
// Iterative multiply/divide unit for MULT/MULTU/DIV/DIVU: sign-magnitude entry,
// WIDTH radix-2 iterations, then sign correction into the HI/LO registers.
module alu_muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam int W2 = 2 * WIDTH;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  // Handshake: start is taken only when busy is low (IDLE); done pulses one
  // cycle when HI/LO/div_zero change. No back-pressure on the result side.
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t state, state_next;

  logic [CW-1:0]    cnt;
  logic             is_div, sign_a, sign_b;
  logic [WIDTH-1:0] a_orig, mag_a, mag_b;
  logic [W2-1:0]    acc;

  logic             in_sa, in_sb;
  logic [WIDTH-1:0] in_mag_a, in_mag_b;
  logic [WIDTH:0]   mul_sum, rem_shift, div_diff;
  logic [W2-1:0]    mul_next, div_next, prod_fix;
  logic             neg_q;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  always_comb begin
    in_sa    = ~op[0] & A[WIDTH-1];
    in_sb    = ~op[0] & B[WIDTH-1];
    in_mag_a = (A ^ {WIDTH{in_sa}}) + WIDTH'(in_sa);
    in_mag_b = (B ^ {WIDTH{in_sb}}) + WIDTH'(in_sb);
  end

  // Multiply adds into the upper half and shifts right; divide shifts the
  // dividend out of the lower half while quotient bits shift in behind it.
  always_comb begin
    mul_sum   = {1'b0, acc[W2-1:WIDTH]} + {1'b0, (acc[0] ? mag_b : '0)};
    mul_next  = {mul_sum, acc[WIDTH-1:1]};
    rem_shift = {acc[W2-1:WIDTH], acc[WIDTH-1]};
    div_diff  = rem_shift - {1'b0, mag_b};
    div_next  = div_diff[WIDTH] ? {rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  end

  always_comb begin
    neg_q    = sign_a ^ sign_b;
    prod_fix = (acc ^ {W2{neg_q}}) + W2'(neg_q);
    quo_fix  = (acc[WIDTH-1:0] ^ {WIDTH{neg_q}}) + WIDTH'(neg_q);
    rem_fix  = (acc[W2-1:WIDTH] ^ {WIDTH{sign_a}}) + WIDTH'(sign_a);
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    case (state)
      IDLE: if (start) state_next = RUN;
      RUN: begin
        busy = 1'b1;
        if (cnt == LAST) state_next = FIX;
      end
      FIX: begin
        busy       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt      <= '0;
      is_div   <= 1'b0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      a_orig   <= '0;
      mag_a    <= '0;
      mag_b    <= '0;
      acc      <= '0;
      HI       <= '0;
      LO       <= '0;
      div_zero <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          is_div <= op[1];
          sign_a <= in_sa;
          sign_b <= in_sb;
          a_orig <= A;
          mag_a  <= in_mag_a;
          mag_b  <= in_mag_b;
          acc    <= {{WIDTH{1'b0}}, in_mag_a};
          cnt    <= '0;
        end
        RUN: begin
          acc <= is_div ? div_next : mul_next;
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          done <= 1'b1;
          if (!is_div) begin
            {HI, LO} <= prod_fix;
            div_zero <= 1'b0;
          end else if (mag_b == '0) begin
            HI       <= a_orig;
            LO       <= '1;
            div_zero <= 1'b1;
          end else begin
            HI       <= rem_fix;
            LO       <= quo_fix;
            div_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed bench for alu_muldiv_seq: hand-computed HI/LO/div_zero, latency,
// busy/done timing, ignored start, back-to-back start and mid-run reset.
module tb_alu_muldiv_seq;

  localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01,
                         OP_DIV  = 2'b10, OP_DIVU  = 2'b11;

  logic        clk, rst, start, busy, done, div_zero;
  logic [1:0]  op;
  logic [31:0] A, B, HI, LO;

  int checks = 0;
  int errors = 0;
  logic [64:0] exp_q[$];

  alu_muldiv_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .A(A), .B(B),
    .busy(busy), .done(done), .HI(HI), .LO(LO), .div_zero(div_zero)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive a request at a negedge; returns just after the accept edge E0.
  task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; A = a; B = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    op = 2'($urandom_range(0, 3));
    A  = $urandom;
    B  = $urandom;
  endtask

  // Waits for done (bounded). cycles = edges seen; gap = busy dropped early.
  task automatic wait_done(output int cycles, output bit gap, output bit got);
    cycles = 0; gap = 1'b0; got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      @(negedge clk);
      cycles++;
      if (done) begin
        got = 1'b1;
        break;
      end
      if (!busy) gap = 1'b1;
    end
  endtask

  task automatic check_result(input string tag);
    logic [64:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 65'd1, 65'd0);
    end else begin
      e = exp_q.pop_front();
      check(tag, {div_zero, HI, LO}, e);
    end
  endtask

  task automatic run_case(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi,
                          input logic [31:0] elo, input logic edz);
    int cyc; bit gap, got;
    exp_q.push_back({edz, ehi, elo});
    start_op(o, a, b);
    wait_done(cyc, gap, got);
    check({tag, "_latency"}, 65'(cyc), 65'd33);
    check({tag, "_busy"}, {64'd0, gap | busy}, 65'd0);
    check_result(tag);
  endtask

  initial begin
    int cyc, npulse; bit gap, got;
    rst = 1'b0; start = 1'b0; op = 2'b00; A = '0; B = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", {62'd0, busy, done, div_zero, HI, LO}, 65'd0);
    rst = 1'b1;

    // first op: detailed busy/done timing
    run_case("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    @(posedge clk); @(negedge clk);
    check("done_one_cycle", {64'd0, done}, 65'd0);
    check("hold_after_done", {div_zero, HI, LO}, {1'b0, 32'hFFFFFFFE, 32'h00000001});

    run_case("mult_neg3x5", OP_MULT, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
    run_case("mult_min_sq", OP_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 1'b0);
    run_case("div_neg7_2", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run_case("div_7_neg2", OP_DIV, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 1'b0);
    run_case("divu_7_2", OP_DIVU, 32'd7, 32'd2, 32'd1, 32'd3, 1'b0);
    run_case("div_overflow", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0);
    run_case("divu_by_zero", OP_DIVU, 32'h1234, 32'd0, 32'h1234, 32'hFFFFFFFF, 1'b1);
    run_case("multu_2x3", OP_MULTU, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0);
    run_case("div_neg_by_zero", OP_DIV, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1);
    run_case("divu_big", OP_DIVU, 32'hFFFFFFFF, 32'h00010000, 32'h0000FFFF, 32'h0000FFFF, 1'b0);

    // start pulsed at E5 of a running op is ignored
    exp_q.push_back({1'b0, 32'd0, 32'd200});
    start_op(OP_MULTU, 32'd10, 32'd20);
    repeat (4) begin @(posedge clk); @(negedge clk); end
    start = 1'b1; op = OP_DIVU; A = 32'd99; B = 32'd3;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    wait_done(cyc, gap, got);
    check("ignored_start_latency", 65'(cyc), 65'd28);
    check_result("ignored_start");

    // start in the done cycle is accepted; next done 34 cycles after this one
    exp_q.push_back({1'b0, 32'd1, 32'd0});
    start_op(OP_MULTU, 32'h00010000, 32'h00010000);
    wait_done(cyc, gap, got);
    check("b2b_latency", 65'(cyc + 1), 65'd34);
    check_result("b2b");

    // reset at E10 of a divide aborts it
    start_op(OP_DIV, 32'd100, 32'd7);
    repeat (9) begin @(posedge clk); @(negedge clk); end
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    check("midrun_reset", {62'd0, busy, done, div_zero, HI, LO}, 65'd0);
    npulse = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); @(negedge clk);
      if (done) npulse++;
    end
    check("no_done_after_abort", 65'(npulse), 65'd0);
    run_case("divu_after_reset", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);

    check("queue_empty", 65'(exp_q.size()), 65'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_muldiv_seq.md
Name: alu_muldiv_seq

Overview:
- Iterative 32-bit multiply/divide unit downstream of the 1-bit-to-32-bit mask replicator in the ALU datapath.
- Each operand sign bit is replicated to a 32-bit mask `{32{s}}`. The unit uses `(x ^ mask) + s` to take absolute values on entry and to apply sign correction on exit.
- Serves the CPU's MULT/MULTU/DIV/DIVU instructions.
- Results go to HI/LO registers, read by the register-file writeback path.

Parameters:
- WIDTH, 32: operand width; iteration count equals WIDTH. Only 32 is required to be verified.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous reset, active-low; sampled on rising edge of clk.
- start  input  1  request. Accepted only in IDLE.
- op  input  2  operation: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- A  input  WIDTH  multiplicand / dividend. Sampled on the accept edge only.
- B  input  WIDTH  multiplier / divisor. Sampled on the accept edge only.
- busy  output  1  high while an operation is in flight (RUN, FIX).
- done  output  1  one-cycle pulse when HI/LO/div_zero are updated.
- HI  output  WIDTH  MUL: product[63:32]; DIV: remainder.
- LO  output  WIDTH  MUL: product[31:0]; DIV: quotient.
- div_zero  output  1  set with done when a DIV/DIVU had B==0; cleared at the next completion without B==0.

Behaviour:
- Reset (rst==0 at a rising edge):
  - state=IDLE.
  - busy=0, done=0, HI=0, LO=0, div_zero=0.
  - Iteration counter and internal operand registers cleared.
  - Reset applies in any state, including mid-RUN; the aborted operation produces no done.
- States: IDLE, RUN, FIX.
  - IDLE: busy=0.
    - On an edge with start=1: latch op, A, B, signA and signB.
    - signA/signB = MSB when op is signed, else 0.
    - Store |A| and |B| via mask-XOR-plus-sign, clear the accumulator, cnt=0, go to RUN.
  - RUN: busy=1. One iteration per edge, cnt increments.
    - Multiply: shift-add radix-2, 64-bit accumulator.
    - Divide: restoring, one quotient bit per edge.
    - On the edge where cnt==WIDTH-1, go to FIX.
  - FIX: busy=1.
    - Sign correction:
      - MULT: negate the 64-bit product if signA^signB.
      - DIV: negate the quotient if signA^signB; negate the remainder if signA (remainder sign follows dividend).
    - Register HI/LO/div_zero. Go to IDLE and set done=1 for exactly one cycle.
- Latency:
  - Accept edge = E0. Iterations occur on E1..E32. Results and done are visible after E33; done drops after E34.
  - busy is high after E0 through after E32 and is low in the done cycle.
  - Latency is fixed for all ops and operands, including divide-by-zero.
- start while busy=1: ignored, with no queuing. start in the done cycle is in IDLE and is accepted normally.
- HI/LO/div_zero hold their values from the last completion until the next completion or reset.
- Arithmetic: all intermediates are modulo 2^WIDTH (or 2^(2·WIDTH) for the product).
  - Negation of 0x80000000 yields 0x80000000, whose unsigned magnitude 2^31 is exact.
- Divide by zero (B==0, DIV or DIVU): LO=0xFFFFFFFF, HI=A (the original, unmodified value), div_zero=1. Sign correction is skipped.
- Signed overflow (DIV 0x80000000 / 0xFFFFFFFF): LO=0x80000000, HI=0, div_zero=0.
- op changes and A/B changes after E0 have no effect on the current operation.

Test Plan:
- Reset, then MULTU A=0xFFFFFFFF B=0xFFFFFFFF, start at E0 -> after E33: HI=0xFFFFFFFE, LO=0x00000001, done high one cycle, busy high from E0 to E32 only.
- MULT A=0xFFFFFFFD(-3) B=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1. MULT A=0x80000000 B=0x80000000 -> HI=0x40000000, LO=0.
- DIV A=0xFFFFFFF9(-7) B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU A=7 B=2 -> LO=3, HI=1. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0, div_zero=0.
- DIVU A=0x1234 B=0 -> after E33: LO=0xFFFFFFFF, HI=0x1234, div_zero=1. Next MULTU 2*3 -> HI=0, LO=6, div_zero=0.
- Pulse start with different A/B at E5 of a running op -> ignored; the result matches the first operands. Assert start in the done cycle -> accepted, new done 34 cycles later.
- Hold rst=0 at E10 of a DIV -> next cycle busy=0, done=0, HI=LO=0. No done appears afterwards. A new op started after release completes correctly.
